// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared types and helpers for the bit-serial adder.
//   sa_state_t : FSM state encoding (IDLE, RUN, DONE)
//   cnt_width  : width of the bit counter for an N-bit operand
//   DEFAULT_N  : default operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int DEFAULT_N = 4;

  // Counter must hold 0..N-1; keep at least one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if
// Request/response bundle between a requester (master) and the adder (slave).
//   start, a, b, cin : request, driven by master
//   ready, valid     : handshake status, driven by slave
//   sum, cout        : result, driven by slave
//   ovf              : signed overflow, only when SERIAL_ADDER_OVF_EN is defined
interface serial_adder_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         ready;
  logic         valid;
  logic [N-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  ready, valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output ready, valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/serial_adder_full_adder.sv
// full_adder
// Single-bit combinational full adder; the only arithmetic cell of the
// serial adder.
//   a, b, cin : operand bits and carry in
//   s         : sum bit
//   cout      : carry out (majority of the three inputs)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial N-bit adder: one bit per clock, LSB first, through one full
// adder. A request is accepted on a clock edge where start=1 while ready=1;
// {cout,sum} is final when valid pulses N cycles later, and the next request
// can be accepted two cycles after that (one operation per N+2 cycles).
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : serial_adder_if slave (start/a/b/cin in; ready/valid/sum/cout out)
// Optional feature: define SERIAL_ADDER_OVF_EN to add a registered two's-
// complement overflow flag (bus.ovf) that holds alongside sum.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus
);

  localparam int              CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  sa_state_t        state_reg;
  logic [N-1:0]     sa_reg;
  logic [N-1:0]     sb_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [N-1:0]     sum_reg;
  logic             cout_reg;
  logic             ready_reg;
  logic             valid_reg;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_reg;
`endif

  logic fa_s;
  logic fa_c;

  full_adder u_fa (
    .a    (sa_reg[0]),
    .b    (sb_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg <= RUN;
            sa_reg    <= bus.a;
            sb_reg    <= bus.b;
            carry_reg <= bus.cin;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ready_reg <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_reg   <= 1'b0;
`endif
          end
        end

        RUN: begin
          // New sum bit enters at the MSB; after N shifts bit 0 sits at the LSB.
          sum_reg   <= {fa_s, sum_reg[N-1:1]};
          sa_reg    <= sa_reg >> 1;
          sb_reg    <= sb_reg >> 1;
          carry_reg <= fa_c;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            state_reg <= DONE;
            cout_reg  <= fa_c;
            valid_reg <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_reg is the carry into the MSB on this final bit.
            ovf_reg   <= carry_reg ^ fa_c;
`endif
          end
        end

        DONE: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
        end

        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready = ready_reg;
  assign bus.valid = valid_reg;
  assign bus.sum   = sum_reg;
  assign bus.cout  = cout_reg;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf   = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Self-checking bench for serial_adder with N=4: directed vector table,
// hand-written busy/reset sequences, and a back-to-back random run checked
// against plain integer arithmetic. Overflow checks compile in when
// SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  serial_adder_if #(.N(N)) bus ();

  serial_adder #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact unsigned sum and signed overflow from integer arithmetic.
  function automatic logic [4:0] model_sum(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int s;
    s = int'(a) + int'(b) + int'(cin);
    return 5'(s);
  endfunction

  function automatic logic model_ovf(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int sa;
    int sb;
    int s;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    s  = sa + sb + int'(cin);
    return (s > 7) || (s < -8);
  endfunction

  // Called at a negedge. Waits for ready, issues one request, returns the
  // result and the number of cycles from the accepting edge to valid.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        output logic [4:0] res, output logic ovf_o, output int lat);
    int k;
    k = 0;
    while (bus.ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (bus.ready !== 1'b1) check("ready_wait_timeout", 32'(bus.ready), 32'd1);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("ready_low_after_accept", 32'(bus.ready), 32'd0);
    lat = 0;
    while (bus.valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = {bus.cout, bus.sum};
`ifdef SERIAL_ADDER_OVF_EN
    ovf_o = bus.ovf;
`else
    ovf_o = 1'b0;
`endif
    @(negedge clk);
    check("valid_single_pulse", 32'(bus.valid), 32'd0);
    check("ready_back_after_done", 32'(bus.ready), 32'd1);
    check("result_holds", 32'({bus.cout, bus.sum}), 32'(res));
    $display("op a=%h b=%h cin=%0d -> %h lat=%0d", a, b, cin, res, lat);
  endtask

  // Reset two edges into a run: result must be discarded.
  task automatic mid_reset(input logic [3:0] a, input logic [3:0] b);
    int nv;
    int k;
    k = 0;
    while (bus.ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    bus.a = a; bus.b = b; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_valid", 32'(bus.valid), 32'd0);
    check("midrst_sum", 32'(bus.sum), 32'd0);
    check("midrst_cout", 32'(bus.cout), 32'd0);
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) nv++;
    end
    check("midrst_no_valid", 32'(nv), 32'd0);
    $display("mid-run reset a=%h b=%h valids=%0d", a, b, nv);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] res;
    logic       ovf_v;
    int         lat;
    int         nv;
    logic [4:0] busy_res;
    logic [4:0] expq [$];
    logic       ovq  [$];
    logic [4:0] e;
    logic       eo;
    int         results;
    int         cnt;
    int         last_acc;
    bit         just_acc;

    vecs[0] = '{a: 4'h3, b: 4'h4, cin: 1'b0, exp: 5'h07};
    vecs[1] = '{a: 4'h7, b: 4'h9, cin: 1'b0, exp: 5'h10};
    vecs[2] = '{a: 4'hF, b: 4'hF, cin: 1'b1, exp: 5'h1F};
    vecs[3] = '{a: 4'h0, b: 4'h0, cin: 1'b0, exp: 5'h00};
    vecs[4] = '{a: 4'hF, b: 4'h0, cin: 1'b1, exp: 5'h10};
    vecs[5] = '{a: 4'hA, b: 4'h5, cin: 1'b0, exp: 5'h0F};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_sum", 32'(bus.sum), 32'd0);
    check("reset_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset_ovf", 32'(bus.ovf), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, res, ovf_v, lat);
      check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(N));
    end

    // Busy rejection: a start pulse during RUN must be ignored, not queued.
    bus.a = 4'h1; bus.b = 4'h1; bus.cin = 1'b0; bus.start = 1'b1;
    check("busy_ready_before", 32'(bus.ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.a = 4'h5; bus.b = 4'h5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    nv = 0;
    busy_res = '0;
    for (int i = 0; i < 12; i++) begin
      if (bus.valid === 1'b1) begin
        nv++;
        busy_res = {bus.cout, bus.sum};
      end
      @(negedge clk);
    end
    check("busy_valid_count", 32'(nv), 32'd1);
    check("busy_result", 32'(busy_res), 32'h02);
    $display("busy rejection valids=%0d result=%h", nv, busy_res);

    // Mid-run reset, then a clean operation.
    mid_reset(4'hF, 4'h1);
    mid_reset(4'h7, 4'h0);
    run_op(4'h2, 4'h2, 1'b0, res, ovf_v, lat);
    check("after_reset_result", 32'(res), 32'h04);

`ifdef SERIAL_ADDER_OVF_EN
    run_op(4'h7, 4'h1, 1'b0, res, ovf_v, lat);
    check("ovf_7p1_sum", 32'(res), 32'h08);
    check("ovf_7p1_ovf", 32'(ovf_v), 32'd1);
    run_op(4'hF, 4'h1, 1'b0, res, ovf_v, lat);
    check("ovf_Fp1_sum", 32'(res), 32'h10);
    check("ovf_Fp1_ovf", 32'(ovf_v), 32'd0);
    run_op(4'h8, 4'h8, 1'b0, res, ovf_v, lat);
    check("ovf_8p8_sum", 32'(res), 32'h10);
    check("ovf_8p8_ovf", 32'(ovf_v), 32'd1);
`endif

    // Back-to-back random run with start held high.
    results  = 0;
    cnt      = 0;
    last_acc = -1;
    just_acc = 1'b0;
    bus.a     = 4'($urandom);
    bus.b     = 4'($urandom);
    bus.cin   = 1'($urandom);
    bus.start = 1'b1;
    while (results < 175 && cnt < 175 * 6 + 60) begin
      if (just_acc) begin
        bus.a   = 4'($urandom);
        bus.b   = 4'($urandom);
        bus.cin = 1'($urandom);
        just_acc = 1'b0;
      end
      if (bus.valid === 1'b1) begin
        if (expq.size() == 0) begin
          check("b2b_unexpected_valid", 32'd1, 32'd0);
        end else begin
          e  = expq.pop_front();
          eo = ovq.pop_front();
          check("b2b_result", 32'({bus.cout, bus.sum}), 32'(e));
`ifdef SERIAL_ADDER_OVF_EN
          check("b2b_ovf", 32'(bus.ovf), 32'(eo));
`endif
          $display("b2b #%0d result=%h expected=%h ovf_exp=%0d", results, {bus.cout, bus.sum}, e, eo);
        end
        results++;
      end
      if (bus.ready === 1'b1) begin
        expq.push_back(model_sum(bus.a, bus.b, bus.cin));
        ovq.push_back(model_ovf(bus.a, bus.b, bus.cin));
        if (last_acc >= 0) check("b2b_accept_interval", 32'(cnt - last_acc), 32'(N + 2));
        last_acc = cnt;
        just_acc = 1'b1;
      end
      @(negedge clk);
      cnt++;
    end
    bus.start = 1'b0;
    check("b2b_result_count", 32'(results), 32'd175);
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder that accepts two operands and a carry-in through a start/ready handshake. It processes one bit per clock, LSB first, through a single full-adder cell, and returns {cout,sum} with a one-cycle valid pulse. It is the sequential, area-minimal counterpart to the combinational adder in the lab. It is exercised by the same random-stimulus, golden-vector bench style, with {cout,sum} compared against a + b + cin.

## Interface
- N, default 4: operand width in bits; N ≥ 2.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- a  input  N  operand A; captured on the accepting edge.
- b  input  N  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- ready  output  1  high only in IDLE.
- valid  output  1  one-cycle pulse; sum/cout are final.
- sum  output  N  result bits.
- cout  output  1  carry out of bit N-1.
- ovf  output  1  signed overflow; present only under SERIAL_ADDER_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when start=1 at an edge.
  - Load shift registers sa←a, sb←b and carry←cin.
  - Clear sum register and bit counter cnt (width $clog2(N)).
- RUN, each edge:
  - Full adder computes s = sa[0]^sb[0]^carry and c = majority(sa[0], sb[0], carry).
  - s shifts into sum at MSB; sum shifts right.
  - sa and sb shift right; carry←c; cnt increments.
  - On the edge where cnt = N-1: go to DONE and latch cout←c.
- DONE: valid=1 for exactly this cycle; next edge → IDLE.
- sum and cout hold their final values from DONE until the next accepted start. On the accepting edge they clear to 0.
- start while ready=0 is ignored; it is not queued.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(N+1); exact, with no truncation.
- Reset, from any state including mid-RUN: next state IDLE, and all outputs take their reset values. Any partial result is discarded.

## Timing
- Reset values: ready=1 (IDLE), valid=0, sum=0, cout=0, ovf=0.
- Accept edge E0 (start=1, ready=1).
  - ready is low from E0 until the edge that leaves DONE.
  - Bits 0..N-1 are processed on edges E1..EN.
  - valid is high between EN and EN+1.
- Latency: valid asserts N cycles after the accepting edge.
- Back-to-back throughput: one operation per N+2 cycles.
  - ready returns after EN+1.
  - The earliest next accept edge is EN+2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - ovf port exists.
  - In DONE, ovf = carry-into-MSB XOR cout (two's-complement overflow).
  - ovf holds with sum and clears on accept and on reset.
- SERIAL_ADDER_OVF_EN undefined:
  - No ovf port and no extra flop.
  - All other behaviour is identical.

## Structure
- serial_adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t.
  - Localparam helpers for the counter width.
- Sub-module full_adder (a, b, cin → s, cout), purely combinational; one instance in serial_adder.
- serial_adder contains the FSM, shift registers, counter and output registers.

## Test plan
All scenarios use N=4.
- Reset: hold reset for 2 cycles → ready=1, valid=0, sum=0, cout=0. Then start with a=3, b=4, cin=0 → valid after 4 cycles, {cout,sum}=5'h07.
- Carry chain: a=4'h7, b=4'h9, cin=0 → {cout,sum}=5'h10. a=4'hF, b=4'hF, cin=1 → 5'h1F.
- Busy rejection: start a=1, b=1; pulse start with a=5, b=5 during RUN → single valid with 5'h02; no second valid.
- Mid-run reset: start a=F, b=1; assert reset 2 cycles later → IDLE next edge, valid never pulses, outputs are 0. A new start with a=2, b=2 → 5'h04.
- Back-to-back: hold start=1 continuously with fresh random a, b, cin → accepts exactly every 6 cycles, and every result equals a+b+cin over 175 random vectors.
- OVF (macro defined): a=7, b=1 → sum=8, ovf=1. a=F, b=1 → sum=0, cout=1, ovf=0. a=8, b=8 → sum=0, cout=1, ovf=1.
